// File: rtl/rca_config_pkg.sv
// Shared types for the RCA config loader: word layout, error codes, write-strobe indices and word decode.
// Latency: n/a (types, constants and a combinational decode function only).
// Backpressure: n/a.
package rca_config_pkg;

  // RCA array geometry
  localparam int NUM_RCAS           = 4;
  localparam int NUM_READ_PORTS     = 4;
  localparam int NUM_WRITE_PORTS    = 2;
  localparam int NUM_GRID_MUXES     = 16;
  localparam int GRID_MUX_INPUTS    = 8;
  localparam int IO_UNIT_MUX_INPUTS = 8;
  localparam int GRID_NUM_ROWS      = 4;

  localparam int RCA_SEL_W = $clog2(NUM_RCAS);

  // One-hot positions within cfg_wr_en
  localparam int CFG_WR_CPU_FB  = 0;
  localparam int CFG_WR_CPU_NFB = 1;
  localparam int CFG_WR_GRID    = 2;
  localparam int CFG_WR_IO      = 3;
  localparam int CFG_WR_RESULT  = 4;
  localparam int CFG_WR_INP_USE = 5;
  localparam int CFG_WR_W       = 6;

  typedef enum logic [3:0] {
    CFG_END     = 4'd0,
    CFG_CPU_FB  = 4'd1,
    CFG_CPU_NFB = 4'd2,
    CFG_GRID    = 4'd3,
    CFG_IO      = 4'd4,
    CFG_RESULT  = 4'd5,
    CFG_INP_USE = 4'd6
  } cfg_word_type_t;

  typedef struct packed {
    cfg_word_type_t wtype;
    logic [11:0]    addr;
    logic [15:0]    data;
  } cfg_word_t;

  typedef enum logic [1:0] {
    CFG_ERR_OK       = 2'd0,
    CFG_ERR_BAD_WORD = 2'd1,
    CFG_ERR_OVERFLOW = 2'd2,
    CFG_ERR_CHECKSUM = 2'd3
  } cfg_err_t;

  typedef struct packed {
    logic                is_end;
    logic                bad;
    logic [CFG_WR_W-1:0] wr_en;
  } cfg_decode_t;

  // Classify a word and pick its strobe. Types 7-15 are out of the enum range
  // and fall to the default arm, which marks them bad.
  function automatic cfg_decode_t cfg_decode(input cfg_word_t w);
    cfg_decode_t d;
    logic [12:0] depth;
    d     = '0;
    depth = '0;
    case (w.wtype)
      CFG_END:     d.is_end = 1'b1;
      CFG_CPU_FB:  begin depth = 13'(NUM_READ_PORTS);  d.wr_en[CFG_WR_CPU_FB]  = 1'b1; end
      CFG_CPU_NFB: begin
        depth = 13'(NUM_WRITE_PORTS);
        d.wr_en[CFG_WR_CPU_NFB] = 1'b1;
        // Non-feedback ports are always destinations.
        if (!w.data[8]) d.bad = 1'b1;
      end
      CFG_GRID:    begin depth = 13'(NUM_GRID_MUXES);  d.wr_en[CFG_WR_GRID]    = 1'b1; end
      CFG_IO:      begin depth = 13'(GRID_NUM_ROWS);   d.wr_en[CFG_WR_IO]      = 1'b1; end
      CFG_RESULT:  begin depth = 13'(NUM_WRITE_PORTS); d.wr_en[CFG_WR_RESULT]  = 1'b1; end
      CFG_INP_USE: begin depth = 13'(GRID_NUM_ROWS);   d.wr_en[CFG_WR_INP_USE] = 1'b1; end
      default:     d.bad = 1'b1;
    endcase
    if (!d.is_end && ({1'b0, w.addr} >= depth)) d.bad = 1'b1;
    if (d.bad) d.wr_en = '0;
    return d;
  endfunction

  // Fold of the 28-bit running XOR that the END word payload must match.
  function automatic logic [15:0] cfg_csum_fold(input logic [27:0] x);
    return x[15:0] ^ {4'b0, x[27:16]};
  endfunction

endpackage

// File: rtl/rca_config_loader.sv
// Fetches config words from memory and issues one config-register write strobe per valid word.
// Latency: min 2 cycles/word (FETCH with same-cycle ack, then EXEC); done pulses one cycle after END executes.
// Backpressure: holds mem_req/mem_addr until mem_ack; abort returns to IDLE on the next cycle without done.
//
// Ports: clk/rst (sync, active high); start/abort/start_rca/cfg_base_addr control; busy/done/done_err status;
//   mem_req/mem_addr/mem_ack/mem_rdata fetch port; cfg_rca_sel/cfg_wr_en/cfg_addr/cfg_data/cfg_src_dest
//   config register file write port.
// Build option: RCA_CFG_LOADER_CHECKSUM_EN enables END-word checksum verification (error code 3).
module rca_config_loader
  import rca_config_pkg::*;
#(
  parameter int MAX_CFG_WORDS = 256,
  parameter int MEM_ADDR_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [RCA_SEL_W-1:0]  start_rca,
  input  logic [MEM_ADDR_W-1:0] cfg_base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            done_err,
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [RCA_SEL_W-1:0]  cfg_rca_sel,
  output logic [CFG_WR_W-1:0]   cfg_wr_en,
  output logic [11:0]           cfg_addr,
  output logic [15:0]           cfg_data,
  output logic                  cfg_src_dest
);

  localparam int CNT_W = $clog2(MAX_CFG_WORDS + 1);
  // Count of words already executed when the word in EXEC is the last one allowed.
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(MAX_CFG_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q,  addr_d;
  logic [RCA_SEL_W-1:0]  rca_q,   rca_d;
  cfg_word_t             word_q,  word_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  cfg_err_t              err_q,   err_d;
`ifdef RCA_CFG_LOADER_CHECKSUM_EN
  logic [27:0]           csum_q,  csum_d;
`endif

  cfg_decode_t           dec;
  logic                  csum_ok;
  logic [CFG_WR_W-1:0]   wr_en;
  logic                  done_pulse;

  assign dec = cfg_decode(word_q);

`ifdef RCA_CFG_LOADER_CHECKSUM_EN
  assign csum_ok = (word_q.data == cfg_csum_fold(csum_q));
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rca_d      = rca_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
`ifdef RCA_CFG_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    wr_en      = '0;
    done_pulse = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d = ST_FETCH;
          addr_d  = cfg_base_addr;
          rca_d   = start_rca;
          cnt_d   = '0;
          err_d   = CFG_ERR_OK;
`ifdef RCA_CFG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (mem_ack) begin
          word_d  = cfg_word_t'(mem_rdata);
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (abort) begin
          state_d = ST_IDLE;          // strobe suppressed
        end else if (dec.is_end) begin
          err_d   = csum_ok ? CFG_ERR_OK : CFG_ERR_CHECKSUM;
          state_d = ST_DONE;
        end else if (cnt_q == LAST_WORD) begin
          // Budget exhausted by a non-END word: that word is not written.
          err_d   = CFG_ERR_OVERFLOW;
          state_d = ST_DONE;
        end else if (dec.bad) begin
          err_d   = CFG_ERR_BAD_WORD;
          state_d = ST_DONE;
        end else begin
          wr_en   = dec.wr_en;
          cnt_d   = cnt_q + CNT_W'(1);
          addr_d  = addr_q + MEM_ADDR_W'(4);
`ifdef RCA_CFG_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ {word_q.addr, word_q.data};
`endif
          state_d = ST_FETCH;
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        done_pulse = !abort;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rca_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      err_q   <= CFG_ERR_OK;
`ifdef RCA_CFG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rca_q   <= rca_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef RCA_CFG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_pulse;
  assign done_err     = err_q;
  assign mem_req      = (state_q == ST_FETCH);
  assign mem_addr     = addr_q;
  assign cfg_rca_sel  = rca_q;
  assign cfg_wr_en    = wr_en;
  assign cfg_addr     = word_q.addr;
  assign cfg_data     = word_q.data;
  assign cfg_src_dest = word_q.data[8];

endmodule

// File: tb/tb_rca_config_loader.sv
// Self-checking bench for rca_config_loader: table of single-word loads plus directed multi-cycle sequences.
// Latency: n/a. Backpressure: memory responder acks after a programmable number of wait cycles.
module tb_rca_config_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  start_rca;
  logic [31:0] cfg_base_addr;
  logic        busy;
  logic        done;
  logic [1:0]  done_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  cfg_rca_sel;
  logic [5:0]  cfg_wr_en;
  logic [11:0] cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_src_dest;

  rca_config_loader #(.MAX_CFG_WORDS(256), .MEM_ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .start_rca(start_rca),
    .cfg_base_addr(cfg_base_addr), .busy(busy), .done(done), .done_err(done_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cfg_rca_sel(cfg_rca_sel), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_src_dest(cfg_src_dest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [5:0]  wr;
    logic [11:0] addr;
    logic [15:0] data;
    logic        sd;
    logic [1:0]  rca;
  } strb_t;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  wr;
    logic [11:0] addr;
    logic [15:0] data;
    logic        sd;
    logic [1:0]  err;
  } vec_t;

  localparam int NV = 14;
  vec_t        vecs[NV];
  logic [31:0] mem[512];
  strb_t       strb_q[$];
  logic [31:0] fetch_q[$];
  int          done_cnt;
  logic [1:0]  last_err;
  int          onehot_bad;
  int          ack_delay;
  int          wait_cnt;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] end_word(input logic [27:0] x, input logic flip);
    logic [15:0] f;
    f = x[15:0] ^ {4'b0, x[27:16]};
    return {16'h0000, f ^ {15'b0, flip}};
  endfunction

  // Memory responder: acks after ack_delay wait cycles of a held request.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[10:2]];
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Observer: logs strobes, accepted fetches and done pulses.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (cfg_wr_en != 6'b0) begin
          if ($countones(cfg_wr_en) != 1) onehot_bad++;
          strb_q.push_back('{cfg_wr_en, cfg_addr, cfg_data, cfg_src_dest, cfg_rca_sel});
        end
        if (mem_req && mem_ack) fetch_q.push_back(mem_addr);
        if (done) begin
          done_cnt++;
          last_err = done_err;
        end
      end
    end
  end

  task automatic clear_logs();
    strb_q.delete();
    fetch_q.delete();
    done_cnt = 0;
    last_err = 2'bxx;
  endtask

  task automatic run_load(input string tag, input logic [1:0] rca, input logic [31:0] base, input int budget);
    int cyc;
    clear_logs();
    @(negedge clk);
    start_rca     = rca;
    cfg_base_addr = base;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    #3;
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int   nexp;
    int   cyc;
    logic found;
    logic [27:0] x;

    n_chk = 0; n_fail = 0; onehot_bad = 0; done_cnt = 0; last_err = '0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_rca = '0; cfg_base_addr = '0; ack_delay = 0;
    for (int i = 0; i < 512; i++) mem[i] = '0;

    //          word           wr         addr    data      sd    err
    vecs[0]  = '{32'h3003_0005, 6'b000100, 12'd3, 16'h0005, 1'b0, 2'd0};
    vecs[1]  = '{32'h1002_0113, 6'b000001, 12'd2, 16'h0113, 1'b1, 2'd0};
    vecs[2]  = '{32'h2001_0105, 6'b000010, 12'd1, 16'h0105, 1'b1, 2'd0};
    vecs[3]  = '{32'h2001_0005, 6'b000000, 12'd0, 16'h0000, 1'b0, 2'd1};
    vecs[4]  = '{32'h4003_0007, 6'b001000, 12'd3, 16'h0007, 1'b0, 2'd0};
    vecs[5]  = '{32'h5001_00AB, 6'b010000, 12'd1, 16'h00AB, 1'b0, 2'd0};
    vecs[6]  = '{32'h6000_F1F0, 6'b100000, 12'd0, 16'hF1F0, 1'b1, 2'd0};
    vecs[7]  = '{32'h3010_0001, 6'b000000, 12'd0, 16'h0000, 1'b0, 2'd1};
    vecs[8]  = '{32'h9000_0000, 6'b000000, 12'd0, 16'h0000, 1'b0, 2'd1};
    vecs[9]  = '{32'h1004_0001, 6'b000000, 12'd0, 16'h0000, 1'b0, 2'd1};
    vecs[10] = '{32'h5002_0000, 6'b000000, 12'd0, 16'h0000, 1'b0, 2'd1};
    vecs[11] = '{32'h0000_0000, 6'b000000, 12'd0, 16'h0000, 1'b0, 2'd0};
    vecs[12] = '{32'h4004_0000, 6'b000000, 12'd0, 16'h0000, 1'b0, 2'd1};
    vecs[13] = '{32'h7000_0000, 6'b000000, 12'd0, 16'h0000, 1'b0, 2'd1};

    repeat (3) @(negedge clk);
    #3;
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_done",     32'(done),         32'd0);
    chk("rst_done_err", 32'(done_err),     32'd0);
    chk("rst_mem_req",  32'(mem_req),      32'd0);
    chk("rst_mem_addr", mem_addr,          32'd0);
    chk("rst_wr_en",    32'(cfg_wr_en),    32'd0);
    chk("rst_rca_sel",  32'(cfg_rca_sel),  32'd0);
    chk("rst_cfg_addr", 32'(cfg_addr),     32'd0);
    chk("rst_cfg_data", 32'(cfg_data),     32'd0);
    chk("rst_src_dest", 32'(cfg_src_dest), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: each word followed by a matching END, base 0x100, RCA 1.
    for (int i = 0; i < NV; i++) begin
      mem[64] = vecs[i].w;
      mem[65] = end_word(vecs[i].w[27:0], 1'b0);
      run_load($sformatf("v%0d", i), 2'd1, 32'h100, 200);
      nexp = (vecs[i].wr != 6'b0) ? 2 : 1;
      chk($sformatf("v%0d_err", i),    32'(last_err),       32'(vecs[i].err));
      chk($sformatf("v%0d_nstrb", i),  32'(strb_q.size()),  32'(nexp - 1));
      chk($sformatf("v%0d_nfetch", i), 32'(fetch_q.size()), 32'(nexp));
      if (fetch_q.size() > 0) chk($sformatf("v%0d_fetch0", i), fetch_q[0], 32'h100);
      if (fetch_q.size() > 1) chk($sformatf("v%0d_fetch1", i), fetch_q[1], 32'h104);
      if (strb_q.size() > 0) begin
        chk($sformatf("v%0d_wr", i),   32'(strb_q[0].wr),   32'(vecs[i].wr));
        chk($sformatf("v%0d_addr", i), 32'(strb_q[0].addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_data", i), 32'(strb_q[0].data), 32'(vecs[i].data));
        chk($sformatf("v%0d_sd", i),   32'(strb_q[0].sd),   32'(vecs[i].sd));
        chk($sformatf("v%0d_rca", i),  32'(strb_q[0].rca),  32'd1);
      end
    end
    #3;
    chk("busy_after_load", 32'(busy), 32'd0);

    // Multi-word load with running checksum.
    mem[64] = 32'h3003_0005;
    mem[65] = 32'h4001_0033;
    x = 28'h003_0005 ^ 28'h001_0033;
    mem[66] = end_word(x, 1'b0);
    run_load("multi", 2'd3, 32'h100, 200);
    chk("multi_err",    32'(last_err),       32'd0);
    chk("multi_nstrb",  32'(strb_q.size()),  32'd2);
    chk("multi_nfetch", 32'(fetch_q.size()), 32'd3);
    if (fetch_q.size() == 3) chk("multi_fetch2", fetch_q[2], 32'h108);
    if (strb_q.size() == 2) begin
      chk("multi_wr1",  32'(strb_q[1].wr),  32'h08);
      chk("multi_rca1", 32'(strb_q[1].rca), 32'd3);
    end

    // Good word then type 9: one strobe, bad-word error, no third fetch.
    mem[64] = 32'h3001_0002;
    mem[65] = 32'h9000_0000;
    mem[66] = 32'h3002_0003;
    run_load("bad2", 2'd0, 32'h100, 200);
    chk("bad2_err",    32'(last_err),       32'd1);
    chk("bad2_nstrb",  32'(strb_q.size()),  32'd1);
    chk("bad2_nfetch", 32'(fetch_q.size()), 32'd2);

    // Checksum: END payload off by one bit.
    mem[64] = 32'h3003_0005;
    mem[65] = end_word(28'h003_0005, 1'b1);
    run_load("csum", 2'd0, 32'h100, 200);
`ifdef RCA_CFG_LOADER_CHECKSUM_EN
    chk("csum_err", 32'(last_err), 32'd3);
`else
    chk("csum_err", 32'(last_err), 32'd0);
`endif
    chk("csum_nstrb", 32'(strb_q.size()), 32'd1);

    // Overflow: 256 GRID words and no END in range.
    for (int i = 0; i < 256; i++) mem[64 + i] = 32'h3000_0000 | (32'(i % 16) << 16) | 32'(i);
    mem[320] = 32'h0000_0000;
    run_load("ovf", 2'd2, 32'h100, 3000);
    chk("ovf_err",    32'(last_err),       32'd2);
    chk("ovf_nstrb",  32'(strb_q.size()),  32'd255);
    chk("ovf_nfetch", 32'(fetch_q.size()), 32'd256);
    if (fetch_q.size() == 256) chk("ovf_last_fetch", fetch_q[255], 32'h4FC);
    for (int i = 0; i < 512; i++) mem[i] = '0;

    // Slow memory (5 wait cycles) plus a start while busy that must be ignored.
    mem[64] = 32'h4002_0001;
    mem[65] = end_word(28'h002_0001, 1'b0);
    ack_delay = 5;
    clear_logs();
    @(negedge clk);
    start_rca = 2'd2; cfg_base_addr = 32'h100; start = 1'b1;
    @(negedge clk);
    start_rca = 2'd0; cfg_base_addr = 32'h300; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk($sformatf("slow_req%0d", k),  32'(mem_req),   32'd1);
      chk($sformatf("slow_addr%0d", k), mem_addr,       32'h100);
      chk($sformatf("slow_wr%0d", k),   32'(cfg_wr_en), 32'd0);
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    #3;
    chk("slow_done_cnt", 32'(done_cnt),      32'd1);
    chk("slow_err",      32'(last_err),      32'd0);
    chk("slow_nstrb",    32'(strb_q.size()), 32'd1);
    if (strb_q.size() == 1) chk("slow_rca", 32'(strb_q[0].rca), 32'd2);
    if (fetch_q.size() == 2) chk("slow_fetch1", fetch_q[1], 32'h104);
    else chk("slow_nfetch", 32'(fetch_q.size()), 32'd2);

    // Abort while the third word is being fetched.
    ack_delay = 3;
    for (int i = 0; i < 4; i++) mem[128 + i] = 32'h3000_0000 | (32'(i) << 16) | 32'(i + 1);
    mem[132] = 32'h0000_0000;
    clear_logs();
    @(negedge clk);
    start_rca = 2'd1; cfg_base_addr = 32'h200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      #3;
      if (fetch_q.size() == 2 && mem_req && !mem_ack) found = 1'b1;
    end
    chk("abort_reached_fetch3", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #3;
    chk("abort_busy",    32'(busy),    32'd0);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    repeat (8) @(negedge clk);
    #3;
    chk("abort_no_done", 32'(done_cnt),      32'd0);
    chk("abort_nstrb",   32'(strb_q.size()), 32'd2);
    ack_delay = 0;
    mem[64] = 32'h3003_0005;
    mem[65] = end_word(28'h003_0005, 1'b0);
    run_load("restart", 2'd0, 32'h100, 200);
    chk("restart_err",   32'(last_err),      32'd0);
    chk("restart_nstrb", 32'(strb_q.size()), 32'd1);

    // start and abort together in IDLE: abort wins.
    clear_logs();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #3;
    chk("sa_busy",    32'(busy),    32'd0);
    chk("sa_mem_req", 32'(mem_req), 32'd0);
    repeat (4) @(negedge clk);
    #3;
    chk("sa_nfetch", 32'(fetch_q.size()), 32'd0);

    chk("onehot_violations", 32'(onehot_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
